// File: rtl/rv32im_bus_arbiter_if.sv
// Bus bundle between the three RV32IM bus masters, the arbiter and the shared
// slave. The slave modport is the arbiter's view. The master modport is the
// view of the surrounding system: the masters plus the slave device.
interface rv32im_bus_arbiter_if #(
  parameter int XLEN = 32
);
  logic            m0_cyc_i, m0_stb_i, m0_we_i;
  logic            m1_cyc_i, m1_stb_i, m1_we_i;
  logic            m2_cyc_i, m2_stb_i, m2_we_i;
  logic [3:0]      m0_sel_i, m1_sel_i, m2_sel_i;
  logic [XLEN-3:0] m0_adr_i, m1_adr_i, m2_adr_i;
  logic [XLEN-1:0] m0_dat_i, m1_dat_i, m2_dat_i;
  logic            m0_ack_o, m1_ack_o, m2_ack_o;
  logic            m0_err_o, m1_err_o, m2_err_o;
  logic [XLEN-1:0] m_dat_o;
  logic            cyc_o, stb_o, we_o;
  logic [3:0]      sel_o;
  logic [XLEN-3:0] adr_o;
  logic [XLEN-1:0] dat_o;
  logic            ack_i, err_i;
  logic [XLEN-1:0] dat_i;
  logic [2:0]      gnt_o;
  logic            timeout_o;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    input  m2_cyc_i, m2_stb_i, m2_we_i, m2_sel_i, m2_adr_i, m2_dat_i,
    output m0_ack_o, m1_ack_o, m2_ack_o, m0_err_o, m1_err_o, m2_err_o,
    output m_dat_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, gnt_o, timeout_o,
    input  ack_i, err_i, dat_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    output m2_cyc_i, m2_stb_i, m2_we_i, m2_sel_i, m2_adr_i, m2_dat_i,
    input  m0_ack_o, m1_ack_o, m2_ack_o, m0_err_o, m1_err_o, m2_err_o,
    input  m_dat_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, gnt_o, timeout_o,
    output ack_i, err_i, dat_i
  );
endinterface

// File: rtl/rv32im_bus_arbiter.sv
// Three-master Wishbone-style arbiter: m0 memory unit, m1 prefetch, m2 external.
// Fixed priority m0 > m1 > m2, no preemption, parks on m1 when idle.
// Optional watchdog: define RV32IM_ARB_TIMEOUT_EN to abort stalled strobes
// after TIMEOUT_CYCLES cycles with an err to the owner and a timeout_o pulse.
module rv32im_bus_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk_i,
  input logic               reset_ni,
  rv32im_bus_arbiter_if.slave bus
);
  localparam logic [0:0] PARKED = 1'b0;
  localparam logic [0:0] OWNED  = 1'b1;
  localparam logic [2:0] PARK_GNT = 3'b010;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("rv32im_bus_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  logic [2:0]                 cyc_v, stb_v, we_v;
  logic [2:0][3:0]            sel_v;
  logic [2:0][XLEN-3:0]       adr_v;
  logic [2:0][XLEN-1:0]       dat_v;
  logic [2:0]                 gnt_q, gnt_d, winner;
  logic [0:0]                 state_q, state_d;
  logic                       own_cyc, own_stb, own_we, stb_live, to_pulse;
  logic [3:0]                 own_sel;
  logic [XLEN-3:0]            own_adr;
  logic [XLEN-1:0]            own_dat;
  logic [2:0]                 ack_v, err_v;

  assign cyc_v = {bus.m2_cyc_i, bus.m1_cyc_i, bus.m0_cyc_i};
  assign stb_v = {bus.m2_stb_i, bus.m1_stb_i, bus.m0_stb_i};
  assign we_v  = {bus.m2_we_i,  bus.m1_we_i,  bus.m0_we_i};
  assign sel_v = {bus.m2_sel_i, bus.m1_sel_i, bus.m0_sel_i};
  assign adr_v = {bus.m2_adr_i, bus.m1_adr_i, bus.m0_adr_i};
  assign dat_v = {bus.m2_dat_i, bus.m1_dat_i, bus.m0_dat_i};

  // Select the granted master's request; nothing from other masters leaks through.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_q[i]) begin
        own_cyc = cyc_v[i];
        own_stb = stb_v[i];
        own_we  = we_v[i];
        own_sel = sel_v[i];
        own_adr = adr_v[i];
        own_dat = dat_v[i];
      end
    end
  end

  // Fixed-priority pick among requesters; park on m1 when nobody asks.
  always_comb begin
    if (cyc_v[0])      winner = 3'b001;
    else if (cyc_v[1]) winner = 3'b010;
    else if (cyc_v[2]) winner = 3'b100;
    else               winner = PARK_GNT;
  end

  // Next grant: only re-arbitrate once the owner has released cyc.
  always_comb begin
    gnt_d   = gnt_q;
    state_d = state_q;
    case (state_q)
      PARKED: begin
        // Grant is m1 here, so m1 asking means it already owns the bus.
        if (cyc_v[1]) begin
          state_d = OWNED;
        end else if (|cyc_v) begin
          gnt_d   = winner;
          state_d = OWNED;
        end
      end
      default: begin
        if (!own_cyc) begin
          gnt_d   = winner;
          state_d = (|cyc_v) ? OWNED : PARKED;
        end
      end
    endcase
  end

  // Grant register and FSM state; reset parks on the prefetch unit.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      gnt_q   <= PARK_GNT;
      state_q <= PARKED;
    end else begin
      gnt_q   <= gnt_d;
      state_q <= state_d;
    end
  end

  // Reset kills the bus immediately, even mid-transaction.
  assign stb_live = reset_ni & own_stb;

`ifdef RV32IM_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        stalled;

  assign stalled  = stb_live & ~bus.ack_i & ~bus.err_i;
  assign to_pulse = stalled && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled strobe cycles of the same owner.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      to_cnt_q <= '0;
    else if (!stalled || to_pulse || (gnt_d != gnt_q))
      to_cnt_q <= '0;
    else
      to_cnt_q <= to_cnt_q + 16'd1;
  end
`else
  assign to_pulse = 1'b0;
`endif

  assign ack_v = {3{reset_ni & bus.ack_i}} & gnt_q & stb_v;
  assign err_v = {3{reset_ni & (bus.err_i | to_pulse)}} & gnt_q & stb_v;

  assign bus.cyc_o     = reset_ni & own_cyc;
  assign bus.stb_o     = stb_live;
  assign bus.we_o      = stb_live & own_we;
  assign bus.sel_o     = own_sel;
  assign bus.adr_o     = own_adr;
  assign bus.dat_o     = own_dat;
  assign bus.m_dat_o   = bus.dat_i;
  assign bus.gnt_o     = gnt_q;
  assign bus.timeout_o = to_pulse;
  assign bus.m0_ack_o  = ack_v[0];
  assign bus.m1_ack_o  = ack_v[1];
  assign bus.m2_ack_o  = ack_v[2];
  assign bus.m0_err_o  = err_v[0];
  assign bus.m1_err_o  = err_v[1];
  assign bus.m2_err_o  = err_v[2];
endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Directed scenarios followed by a randomized run against a behavioural
// owner/priority model of the arbiter.
module tb_rv32im_bus_arbiter;
  localparam int TO = 4;

  logic        clk, rst_n;
  logic [2:0]  t_cyc, t_stb, t_we;
  logic [3:0]  t_sel [3];
  logic [29:0] t_adr [3];
  logic [31:0] t_dat [3];
  logic        t_ack, t_err;
  logic [31:0] t_sdat;
  int          checks, errors;
  int          m_own, m_cnt, n_own;

  rv32im_bus_arbiter_if #(.XLEN(32)) bus ();

  rv32im_bus_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus.slave)
  );

  assign bus.m0_cyc_i = t_cyc[0]; assign bus.m1_cyc_i = t_cyc[1]; assign bus.m2_cyc_i = t_cyc[2];
  assign bus.m0_stb_i = t_stb[0]; assign bus.m1_stb_i = t_stb[1]; assign bus.m2_stb_i = t_stb[2];
  assign bus.m0_we_i  = t_we[0];  assign bus.m1_we_i  = t_we[1];  assign bus.m2_we_i  = t_we[2];
  assign bus.m0_sel_i = t_sel[0]; assign bus.m1_sel_i = t_sel[1]; assign bus.m2_sel_i = t_sel[2];
  assign bus.m0_adr_i = t_adr[0]; assign bus.m1_adr_i = t_adr[1]; assign bus.m2_adr_i = t_adr[2];
  assign bus.m0_dat_i = t_dat[0]; assign bus.m1_dat_i = t_dat[1]; assign bus.m2_dat_i = t_dat[2];
  assign bus.ack_i = t_ack;
  assign bus.err_i = t_err;
  assign bus.dat_i = t_sdat;

  wire [2:0] ack_o = {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o};
  wire [2:0] err_o = {bus.m2_err_o, bus.m1_err_o, bus.m0_err_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    t_cyc = '0; t_stb = '0; t_we = '0; t_ack = 1'b0; t_err = 1'b0;
    for (int n = 0; n < 3; n++) begin
      t_sel[n] = 4'hF; t_adr[n] = '0; t_dat[n] = '0;
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_model();
    logic [2:0] eg;
    logic       stb_e, to_e;
    eg    = 3'(1 << m_own);
    stb_e = t_stb[m_own];
    to_e  = 1'b0;
`ifdef RV32IM_ARB_TIMEOUT_EN
    to_e  = stb_e && !t_ack && !t_err && (m_cnt == TO - 1);
`endif
    chk("r_gnt", 64'(bus.gnt_o), 64'(eg));
    chk("r_cyc", 64'(bus.cyc_o), 64'(t_cyc[m_own]));
    chk("r_stb", 64'(bus.stb_o), 64'(stb_e));
    chk("r_we",  64'(bus.we_o),  64'(stb_e & t_we[m_own]));
    chk("r_sel", 64'(bus.sel_o), 64'(t_sel[m_own]));
    chk("r_adr", 64'(bus.adr_o), 64'(t_adr[m_own]));
    chk("r_dat", 64'(bus.dat_o), 64'(t_dat[m_own]));
    chk("r_mdat", 64'(bus.m_dat_o), 64'(t_sdat));
    chk("r_ack", 64'(ack_o), 64'((stb_e && t_ack) ? eg : 3'b000));
    chk("r_err", 64'(err_o), 64'((stb_e && (t_err || to_e)) ? eg : 3'b000));
    chk("r_to",  64'(bus.timeout_o), 64'(to_e));
    // Advance the model to what the next edge should produce.
    if (t_cyc[m_own])  n_own = m_own;
    else if (t_cyc[0]) n_own = 0;
    else if (t_cyc[1]) n_own = 1;
    else if (t_cyc[2]) n_own = 2;
    else               n_own = 1;
    if (stb_e && !t_ack && !t_err && !to_e && n_own == m_own) m_cnt++;
    else m_cnt = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    clear_masters();
    t_sdat = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, and reset holding the bus quiet against a live request.
    chk("rst_gnt", 64'(bus.gnt_o), 64'(3'b010));
    chk("rst_cyc", 64'(bus.cyc_o), 64'(0));
    chk("rst_to",  64'(bus.timeout_o), 64'(0));
    t_cyc[1] = 1'b1; t_stb[1] = 1'b1; t_ack = 1'b1;
    #1;
    chk("rst_stb_hold", 64'(bus.stb_o), 64'(0));
    chk("rst_ack_hold", 64'(ack_o), 64'(0));
    clear_masters();
    rst_n = 1'b1;
    tick();

    // Parked m1 gets the bus with zero latency.
    t_cyc[1] = 1'b1; t_stb[1] = 1'b1; t_adr[1] = 30'h10;
    #1;
    chk("p1_stb", 64'(bus.stb_o), 64'(1));
    chk("p1_adr", 64'(bus.adr_o), 64'(30'h10));
    chk("p1_gnt", 64'(bus.gnt_o), 64'(3'b010));
    t_ack = 1'b1;
    #1;
    chk("p1_ack", 64'(ack_o), 64'(3'b010));

    // m0 waits behind m1 until m1 drops cyc.
    tick();
    t_cyc[0] = 1'b1; t_stb[0] = 1'b1; t_we[0] = 1'b1; t_dat[0] = 32'hDEADBEEF;
    #1;
    chk("p2_wait_gnt", 64'(bus.gnt_o), 64'(3'b010));
    chk("p2_wait_ack", 64'(ack_o), 64'(3'b010));
    chk("p2_wait_adr", 64'(bus.adr_o), 64'(30'h10));
    tick();
    chk("p2_hold", 64'(bus.gnt_o), 64'(3'b010));
    t_cyc[1] = 1'b0; t_stb[1] = 1'b0; t_ack = 1'b0;
    #1;
    chk("p2_gap_cyc", 64'(bus.cyc_o), 64'(0));
    tick();
    chk("p2_gnt", 64'(bus.gnt_o), 64'(3'b001));
    chk("p2_dat", 64'(bus.dat_o), 64'(32'hDEADBEEF));
    chk("p2_we",  64'(bus.we_o), 64'(1));
    clear_masters();
    tick();
    chk("park", 64'(bus.gnt_o), 64'(3'b010));

    // m0 and m2 together from parked: m0 first, then m2.
    t_cyc[0] = 1'b1; t_stb[0] = 1'b1; t_adr[0] = 30'h100;
    t_cyc[2] = 1'b1; t_stb[2] = 1'b1; t_adr[2] = 30'h200;
    #1;
    chk("p3_lat_gnt", 64'(bus.gnt_o), 64'(3'b010));
    chk("p3_lat_stb", 64'(bus.stb_o), 64'(0));
    tick();
    chk("p3_g0", 64'(bus.gnt_o), 64'(3'b001));
    chk("p3_a0", 64'(bus.adr_o), 64'(30'h100));
    t_cyc[0] = 1'b0; t_stb[0] = 1'b0;
    tick();
    chk("p3_g2", 64'(bus.gnt_o), 64'(3'b100));
    chk("p3_a2", 64'(bus.adr_o), 64'(30'h200));

    // Reset in the middle of an m2 transaction.
    chk("p4_stb", 64'(bus.stb_o), 64'(1));
    #2;
    rst_n = 1'b0; t_ack = 1'b1;
    #1;
    chk("p4_stb0", 64'(bus.stb_o), 64'(0));
    chk("p4_cyc0", 64'(bus.cyc_o), 64'(0));
    chk("p4_gnt",  64'(bus.gnt_o), 64'(3'b010));
    chk("p4_ack",  64'(ack_o), 64'(0));
    t_cyc[2] = 1'b0; t_stb[2] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("p4_post_ack", 64'(ack_o), 64'(0));
    chk("p4_post_gnt", 64'(bus.gnt_o), 64'(3'b010));
    t_ack = 1'b0;

    // err_i during an m1 read completes but does not end ownership.
    t_cyc[1] = 1'b1; t_stb[1] = 1'b1; t_err = 1'b1;
    #1;
    chk("p5_err", 64'(err_o), 64'(3'b010));
    chk("p5_ack", 64'(ack_o), 64'(0));
    tick();
    t_err = 1'b0; t_cyc[0] = 1'b1; t_stb[0] = 1'b1;
    tick();
    chk("p5_own", 64'(bus.gnt_o), 64'(3'b010));
    t_cyc[1] = 1'b0; t_stb[1] = 1'b0;
    tick();
    chk("p5_rel", 64'(bus.gnt_o), 64'(3'b001));
    clear_masters();
    tick();

    // Stalled m0 strobe: watchdog fires on the TO-th stalled cycle only.
    t_cyc[0] = 1'b1; t_stb[0] = 1'b1;
    tick();
    for (int k = 1; k <= TO + 2; k++) begin
`ifdef RV32IM_ARB_TIMEOUT_EN
      chk("p6_to",  64'(bus.timeout_o), 64'(k == TO));
      chk("p6_err", 64'(err_o), 64'((k == TO) ? 3'b001 : 3'b000));
`else
      chk("p6_to_off",  64'(bus.timeout_o), 64'(0));
      chk("p6_err_off", 64'(err_o), 64'(0));
`endif
      tick();
    end
    clear_masters();

    // Randomized traffic against the model, from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_own = 1; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 3; n++) begin
        if (t_cyc[n]) begin
          if ($urandom_range(3) == 0) t_cyc[n] = 1'b0;
        end else if ($urandom_range(3) == 0) t_cyc[n] = 1'b1;
        t_stb[n] = t_cyc[n] & ($urandom_range(3) != 0);
        t_we[n]  = 1'($urandom_range(1));
        t_sel[n] = 4'($urandom);
        t_adr[n] = 30'($urandom);
        t_dat[n] = $urandom;
      end
      t_ack  = ($urandom_range(2) == 0);
      t_err  = !t_ack && ($urandom_range(9) == 0);
      t_sdat = $urandom;
      @(negedge clk);
      check_model();
      @(posedge clk);
      m_own = n_own;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32im_bus_arbiter.md
RV32IM_BUS_ARBITER -- requirements
Module: rv32im_bus_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data bus width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit; legal range 1..65535.
REQ-003 SHALL have port clk_i  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports mN_cyc_i, mN_stb_i, mN_we_i  in  1 each, for N=0..2 (0=memory unit, 1=prefetch, 2=external master): bus request, strobe, write.
REQ-006 SHALL have ports mN_sel_i  in  4, mN_adr_i  in  XLEN-2, mN_dat_i  in  XLEN: byte select, word address, write data per master.
REQ-007 SHALL have ports mN_ack_o, mN_err_o  out  1 each: completion routed to master N.
REQ-008 SHALL have port m_dat_o  out  XLEN: slave read data broadcast to all masters.
REQ-009 SHALL have ports cyc_o, stb_o, we_o  out  1; sel_o  out  4; adr_o  out  XLEN-2; dat_o  out  XLEN: muxed slave-side bus.
REQ-010 SHALL have ports ack_i, err_i  in  1; dat_i  in  XLEN: slave responses.
REQ-011 SHALL have port gnt_o  out  3: one-hot current owner.
REQ-012 SHALL have port timeout_o  out  1: one-cycle watchdog-abort pulse.

Function
REQ-013 SHALL hold a one-hot grant register; exactly one bit set at all times.
REQ-014 SHALL use two states: PARKED (grant=prefetch, no active cycle) and OWNED (granted master has cyc high).
REQ-015 SHALL keep ownership while the owner's cyc_i is high; no preemption mid-cycle.
REQ-016 SHALL re-arbitrate only when owner's cyc_i is low; winner by fixed priority m0 > m1 > m2; grant update registered, effective next cycle.
REQ-017 SHALL park on m1 (gnt_o=3'b010) when no cyc_i is high.
REQ-018 SHALL give zero-cycle latency to a request from the current owner, including parked m1; one-cycle arbitration latency otherwise.
REQ-019 SHALL drive cyc_o, stb_o, we_o, sel_o, adr_o, dat_o combinationally from the granted master only; non-granted inputs never reach the bus.
REQ-020 SHALL route ack_i/err_i to the granted master only, gated by its stb_i; others see 0.
REQ-021 SHALL force we_o=0 whenever stb_o=0.
REQ-022 SHALL, when owner drops cyc_i in the same cycle other masters raise it, grant the highest-priority requester on the next edge.
REQ-023 SHALL treat err_i like ack_i for completion; ownership still ends only on cyc_i low.

Reset
REQ-024 SHALL, on reset_ni low, asynchronously set gnt_o=3'b010, clear watchdog counter, timeout_o=0.
REQ-025 SHALL hold cyc_o=stb_o=0 and all mN_ack_o/mN_err_o=0 while reset_ni is low, including mid-transaction; abandoned transactions are not replayed.

Configuration
REQ-026 SHALL, with RV32IM_ARB_TIMEOUT_EN defined, count cycles with stb_o high and no ack_i/err_i; counter clears on ack_i, err_i, stb_o low or owner change.
REQ-027 SHALL, with RV32IM_ARB_TIMEOUT_EN defined, on count reaching TIMEOUT_CYCLES, assert mN_err_o to the owner and timeout_o for exactly one cycle, then clear the counter.
REQ-028 SHALL, without RV32IM_ARB_TIMEOUT_EN, contain no counter, tie timeout_o to 0, and keep all ports.

Verification
REQ-029 SHALL cover: idle, m1 asserts cyc/stb adr=0x10 -> stb_o same cycle, adr_o=0x10, gnt_o=010, ack routed only to m1.
REQ-030 SHALL cover: m1 owns, m0 requests -> m0 waits; m1 drops cyc -> gnt_o=001 next cycle, m0 write dat=0xDEADBEEF on dat_o with we_o=1.
REQ-031 SHALL cover: m0 and m2 request together while parked, m1 idle -> gnt_o=001 first; after m0 release, gnt_o=100.
REQ-032 SHALL cover: reset_ni low mid-m2 transaction -> stb_o=0 immediately, gnt_o=010, no ack to m2 after release.
REQ-033 SHALL cover: macro defined, TIMEOUT_CYCLES=4, m0 stb held, no ack -> m0_err_o and timeout_o high on 4th stalled cycle, one cycle only.
REQ-034 SHALL cover: err_i during m1 read -> m1_err_o=1, m1_ack_o=0, ownership kept until m1 cyc low.
